nios_simple_touch_panel_spi_cmd: RTL and testbench

- Avalon-MM slave that sends 8-bit conversion commands to the resistive touch-panel ADC (ADS7843-class) over SPI-style pins (cs_n, dclk, din) and captures the 12-bit result from dout.
- Host-to-controller counterpart of the pen-interrupt input port.
- Sits in the nios_simple system. Raises irq when a conversion completes.

---
 rtl/touch_spi_pkg.sv | 32 +++
 rtl/touch_spi_clkdiv.sv | 35 +++
 rtl/nios_simple_touch_panel_spi_cmd.sv | 189 ++++++++++++++++++
 tb/tb_nios_simple_touch_panel_spi_cmd.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_spi_pkg.sv
// ============================================================================
// touch_spi_pkg : shared constants, FSM state type and helpers for the
//                 touch-panel ADC command block. Rev 1.0
// ============================================================================
`default_nettype none

package touch_spi_pkg;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_MASK   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // 1-based dclk rising edges whose dout bit belongs to the 12-bit result
  localparam logic [4:0] CAP_FIRST = 5'd10;
  localparam logic [4:0] CAP_LAST  = 5'd21;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  function automatic logic [4:0] sat_inc(input logic [4:0] v, input logic [4:0] lim);
    return (v >= lim) ? lim : v + 5'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/touch_spi_clkdiv.sv
// ============================================================================
// touch_spi_clkdiv : dclk half-period tick generator, held at zero by restart.
// Rev 1.0
// ============================================================================
`default_nettype none

module touch_spi_clkdiv
  import touch_spi_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == DIV_LAST);
    cnt_d = cnt_q + 8'd1;
    if (restart || tick) cnt_d = 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/nios_simple_touch_panel_spi_cmd.sv
// ============================================================================
// nios_simple_touch_panel_spi_cmd : Avalon-MM slave issuing ADS7843 commands
// and capturing 12-bit results. Optional macro: TOUCH_PEN_TRIGGER_EN. Rev 1.0
// ============================================================================
`default_nettype none

module nios_simple_touch_panel_spi_cmd
  import touch_spi_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int FRAME_BITS = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        cs_n,
  output logic        dclk,
  output logic        din,
`ifdef TOUCH_PEN_TRIGGER_EN
  input  logic        pen_irq_n,
`endif
  input  logic        dout
);

  localparam logic [4:0] FRAME_LAST = 5'(FRAME_BITS);

  state_t      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d, bit_next;
  logic [7:0]  cmd_q, cmd_d, start_cmd;
  logic [6:0]  sh_q, sh_d;
  logic [11:0] cap_q, cap_d, result_q, result_d;
  logic [1:0]  mask_q, mask_d;
  logic        done_q, done_d;
  logic        cs_n_q, cs_n_d, dclk_q, dclk_d, din_q, din_d;
  logic [31:0] readdata_q, readdata_d;
  logic        dout_meta_q, dout_sync_q;
  logic        wr, cmd_wr, idle, start, tick, pen_start, pen_level;
  logic        unused_ok;

  touch_spi_clkdiv #(.CLK_DIV(CLK_DIV)) u_clkdiv (
    .clk     (clk),
    .reset   (reset),
    .restart (idle),
    .tick    (tick)
  );

`ifdef TOUCH_PEN_TRIGGER_EN
  logic pen_meta_q, pen_sync_q, pen_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pen_meta_q <= 1'b1;
      pen_sync_q <= 1'b1;
      pen_prev_q <= 1'b1;
    end else begin
      pen_meta_q <= pen_irq_n;
      pen_sync_q <= pen_meta_q;
      pen_prev_q <= pen_sync_q;
    end
  end

  assign pen_start = mask_q[1] & pen_prev_q & ~pen_sync_q;
  assign pen_level = ~pen_sync_q;
`else
  assign pen_start = 1'b0;
  assign pen_level = 1'b0;
`endif

  assign unused_ok = ^writedata[31:8];

  always_comb begin
    wr        = chipselect & ~write_n;
    cmd_wr    = wr && (address == ADDR_CMD);
    idle      = (state_q == ST_IDLE);
    start     = idle && (cmd_wr || pen_start);
    start_cmd = cmd_wr ? writedata[7:0] : cmd_q;
    bit_next  = sat_inc(bit_cnt_q, FRAME_LAST);

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    sh_d      = sh_q;
    cap_d     = cap_q;
    result_d  = result_q;
    mask_d    = mask_q;
    done_d    = done_q;
    cs_n_d    = cs_n_q;
    dclk_d    = dclk_q;
    din_d     = din_q;

    if (cmd_wr && idle) cmd_d = writedata[7:0];
    if (wr && (address == ADDR_MASK)) begin
      mask_d[0] = writedata[0];
`ifdef TOUCH_PEN_TRIGGER_EN
      mask_d[1] = writedata[1];
`endif
    end
    // Clear first so a completion on the same clk overrides it
    if (wr && (address == ADDR_STATUS)) done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_SETUP;
        cs_n_d    = 1'b0;
        din_d     = start_cmd[7];
        sh_d      = start_cmd[6:0];
        bit_cnt_d = 5'd0;
        cap_d     = 12'd0;
      end
      ST_SETUP, ST_LOW: if (tick) begin
        if (state_q == ST_LOW && bit_cnt_q == FRAME_LAST) begin
          state_d  = ST_HOLD;
          cs_n_d   = 1'b1;
          result_d = cap_q;
          done_d   = 1'b1;
        end else begin
          state_d   = ST_HIGH;
          dclk_d    = 1'b1;
          bit_cnt_d = bit_next;
          if (bit_next >= CAP_FIRST && bit_next <= CAP_LAST)
            cap_d = {cap_q[10:0], dout_sync_q};
        end
      end
      ST_HIGH: if (tick) begin
        state_d = ST_LOW;
        dclk_d  = 1'b0;
        din_d   = sh_q[6];
        sh_d    = {sh_q[5:0], 1'b0};
      end
      ST_HOLD: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    unique case (address)
      ADDR_CMD:  readdata_d = {24'd0, cmd_q};
      ADDR_DATA: readdata_d = {20'd0, result_q};
      ADDR_MASK: readdata_d = {30'd0, mask_q};
      default:   readdata_d = {29'd0, pen_level, ~idle, done_q};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 5'd0;
      cmd_q       <= 8'd0;
      sh_q        <= 7'd0;
      cap_q       <= 12'd0;
      result_q    <= 12'd0;
      mask_q      <= 2'd0;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
      readdata_q  <= 32'd0;
      dout_meta_q <= 1'b0;
      dout_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      sh_q        <= sh_d;
      cap_q       <= cap_d;
      result_q    <= result_d;
      mask_q      <= mask_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      dclk_q      <= dclk_d;
      din_q       <= din_d;
      readdata_q  <= readdata_d;
      dout_meta_q <= dout;
      dout_sync_q <= dout_meta_q;
    end
  end

  assign readdata = readdata_q;
  assign irq      = done_q & mask_q[0];
  assign cs_n     = cs_n_q;
  assign dclk     = dclk_q;
  assign din      = din_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_simple_touch_panel_spi_cmd.sv
// Directed, table-driven bench for nios_simple_touch_panel_spi_cmd with a
// behavioural ADS7843 model on the serial pins.
`timescale 1ns/1ps
`default_nettype none

module tb_nios_simple_touch_panel_spi_cmd;

  logic        clk, reset, chipselect, write_n, dout;
  logic [1:0]  address;
  logic [31:0] writedata, readdata;
  logic        irq, cs_n, dclk, din;
`ifdef TOUCH_PEN_TRIGGER_EN
  logic        pen_irq_n;
  localparam logic [31:0] MASK_RW = 32'h3;
`else
  localparam logic [31:0] MASK_RW = 32'h1;
`endif

  nios_simple_touch_panel_spi_cmd dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .cs_n       (cs_n),
    .dclk       (dclk),
    .din        (din),
`ifdef TOUCH_PEN_TRIGGER_EN
    .pen_irq_n  (pen_irq_n),
`endif
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ADC model: counts dclk rising edges per frame, logs din, drives result bits
  int          rise;
  int          n_trans;
  logic [11:0] adc_val;
  logic        din_log [1:24];

  initial begin
    rise = 0;
    n_trans = 0;
  end
  always @(negedge cs_n) begin
    rise = 0;
    n_trans = n_trans + 1;
  end
  always @(posedge dclk) begin
    rise = rise + 1;
    if (rise >= 1 && rise <= 24) din_log[rise] = din;
  end
  always @(negedge dclk) begin
    if (rise >= 9 && rise <= 20) dout = adc_val[20 - rise];
  end

  int n_cmp;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  function automatic logic [31:0] din_byte();
    logic [7:0] b;
    for (int i = 1; i <= 8; i++) b[8 - i] = din_log[i];
    return {24'd0, b};
  endfunction

  // Full transaction from an idle DUT with cycle-exact status checks
  task automatic run_vec(input logic [7:0] c, input logic [11:0] adc, input logic [31:0] exp_data);
    logic [31:0] v;
    int t0;
    adc_val = adc;
    wr(2'd3, 32'd0);
    t0 = n_trans;
    wr(2'd0, {24'd0, c});
    rd(2'd3, v);  check("status_busy", v, 32'h2);
    repeat (1248) tick();
    rd(2'd3, v);  check("status_hold", v, 32'h3);
    rd(2'd3, v);  check("status_done", v, 32'h1);
    rd(2'd1, v);  check("data", v, exp_data);
    rd(2'd0, v);  check("cmd_readback", v, {24'd0, c});
    check("din_seq", din_byte(), {24'd0, c});
    check("rise_count", rise, 24);
    check("one_transaction", n_trans - t0, 1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [11:0] adc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [31:0] v;
    int t0;
    int cnt;

    vecs[0] = '{8'h93, 12'hA5C, 32'h0000_0A5C};
    vecs[1] = '{8'hD3, 12'hFFF, 32'h0000_0FFF};
    vecs[2] = '{8'h01, 12'h001, 32'h0000_0001};
    vecs[3] = '{8'hB7, 12'h800, 32'h0000_0800};

    n_cmp = 0; n_fail = 0;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0; dout = 1'b0; adc_val = 12'd0;
`ifdef TOUCH_PEN_TRIGGER_EN
    pen_irq_n = 1'b1;
`endif
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_cs_n", {31'd0, cs_n}, 32'h1);
    check("rst_dclk", {31'd0, dclk}, 32'h0);
    check("rst_din", {31'd0, din}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd(a[1:0], v);
      check("rst_reg", v, 32'h0);
    end

    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, v); check("mask_rw", v, MASK_RW);
    wr(2'd2, 32'h0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i].cmd, vecs[i].adc, vecs[i].exp_data);

    // irq follows done & mask
    wr(2'd2, 32'h1);
    run_vec(8'h93, 12'hA5C, 32'h0000_0A5C);
    check("irq_set", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h0);
    check("irq_clear", {31'd0, irq}, 32'h0);
    wr(2'd2, 32'h0);
    run_vec(8'h93, 12'h3C3, 32'h0000_03C3);
    check("irq_masked", {31'd0, irq}, 32'h0);

    // CMD write while busy is dropped
    adc_val = 12'h123;
    wr(2'd3, 32'h0);
    t0 = n_trans;
    wr(2'd0, 32'h93);
    repeat (100) tick();
    wr(2'd0, 32'hD3);
    repeat (1160) tick();
    rd(2'd0, v); check("busy_cmd_kept", v, 32'h93);
    check("busy_din_seq", din_byte(), 32'h93);
    check("busy_one_trans", n_trans - t0, 1);
    rd(2'd1, v); check("busy_data", v, 32'h123);

    // STATUS write on the completion clk: done must survive
    adc_val = 12'h456;
    wr(2'd3, 32'h0);
    wr(2'd0, 32'h5A);
    repeat (1224) tick();
    wr(2'd3, 32'h0);
    rd(2'd3, v); check("race_done_wins", v, 32'h3);
    repeat (30) tick();
    rd(2'd3, v); check("race_done_idle", v, 32'h1);

    // Asynchronous reset at rising edge 12
    adc_val = 12'hFFF;
    wr(2'd0, 32'hA7);
    cnt = 0;
    while (rise < 12 && cnt < 2000) begin
      tick();
      cnt++;
    end
    check("reached_edge12", rise, 12);
    reset = 1'b1;
    #1;
    check("arst_cs_n", {31'd0, cs_n}, 32'h1);
    check("arst_dclk", {31'd0, dclk}, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    rd(2'd1, v); check("arst_data", v, 32'h0);
    rd(2'd3, v); check("arst_status", v, 32'h0);
    run_vec(8'hA7, 12'h5A5, 32'h0000_05A5);

`ifdef TOUCH_PEN_TRIGGER_EN
    // Pen falling edge starts a transaction with the stored command
    adc_val = 12'h0F0;
    wr(2'd2, 32'h3);
    wr(2'd3, 32'h0);
    t0 = n_trans;
    pen_irq_n = 1'b0;
    cnt = 0;
    while (cs_n && cnt < 10) begin
      tick();
      cnt++;
    end
    check("pen_latency", {31'd0, (cnt >= 3 && cnt <= 4)}, 32'h1);
    repeat (200) tick();
    pen_irq_n = 1'b1;
    repeat (10) tick();
    pen_irq_n = 1'b0;
    repeat (1300) tick();
    check("pen_one_trans", n_trans - t0, 1);
    check("pen_din_seq", din_byte(), 32'hA7);
    rd(2'd1, v); check("pen_data", v, 32'h0F0);
    rd(2'd3, v); check("pen_status", v, 32'h5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
